// File: rtl/branch_unit_bht.sv
// Execute-stage branch resolver with a direct-mapped BHT of 2-bit saturating counters,
// a registered mispredict/redirect pair and saturating branch/mispredict counters.
module branch_unit_bht #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_INIT  = 1,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [PC_W-1:0]   pcF,
    output logic              pred_takeF,
    input  logic              validE,
    input  logic              stallE,
    input  logic [PC_W-1:0]   pcE,
    input  logic [2:0]        condE,
    input  logic [DATA_W-1:0] src_aE,
    input  logic [DATA_W-1:0] src_bE,
    input  logic              pred_takeE,
    output logic              actual_takeE,
    output logic              mispredictM,
    output logic              actual_takeM,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [1:0] CNT_RST = 2'(CNT_INIT);

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_EQ   = 3'd1;
    localparam logic [2:0] C_NE   = 3'd2;
    localparam logic [2:0] C_GTZ  = 3'd3;
    localparam logic [2:0] C_GEZ  = 3'd4;
    localparam logic [2:0] C_LTZ  = 3'd5;
    localparam logic [2:0] C_LEZ  = 3'd6;
    localparam logic [2:0] C_LTU  = 3'd7;

    logic [1:0]        bht_q [BHT_DEPTH];
    logic [IDX_W-1:0]  idx_f;
    logic [IDX_W-1:0]  idx_e;
    logic [1:0]        cnt_cur;
    logic [1:0]        cnt_d;
    logic              upd;
    logic              mispred;
    logic              a_neg;
    logic              a_zero;
    logic              cond_true;
    logic              mispredict_q, mispredict_d;
    logic              actual_take_q, actual_take_d;
    logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // PC bits outside the index field are deliberately ignored (aliasing is allowed).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[PC_W-1:IDX_W+2], pcF[1:0], pcE[PC_W-1:IDX_W+2], pcE[1:0]};

    assign idx_f      = pcF[IDX_W+1:2];
    assign idx_e      = pcE[IDX_W+1:2];
    assign pred_takeF = bht_q[idx_f][1];

    assign a_neg  = src_aE[DATA_W-1];
    assign a_zero = (src_aE == '0);

    always_comb begin
        cond_true = 1'b0;
        case (condE)
            C_NONE: cond_true = 1'b0;
            C_EQ:   cond_true = (src_aE == src_bE);
            C_NE:   cond_true = (src_aE != src_bE);
            C_GTZ:  cond_true = ~a_neg & ~a_zero;
            C_GEZ:  cond_true = ~a_neg;
            C_LTZ:  cond_true = a_neg;
            C_LEZ:  cond_true = a_neg | a_zero;
            C_LTU:  cond_true = (src_aE < src_bE);
            default: cond_true = 1'b0;
        endcase
    end

    assign actual_takeE = validE & cond_true;
    assign upd          = validE & ~stallE & (condE != C_NONE);
    assign mispred      = actual_takeE ^ pred_takeE;

    always_comb begin
        cnt_cur = bht_q[idx_e];
        cnt_d   = cnt_cur;
        if (actual_takeE && cnt_cur != 2'd3) begin
            cnt_d = cnt_cur + 2'd1;
        end else if (!actual_takeE && cnt_cur != 2'd0) begin
            cnt_d = cnt_cur - 2'd1;
        end
    end

    // Write lands at the edge; a same-index fetch read sees the old value this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_RST;
            end
        end else if (upd) begin
            bht_q[idx_e] <= cnt_d;
        end
    end

    always_comb begin
        mispredict_d  = upd & mispred;
        actual_take_d = actual_takeE;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd && branch_cnt_q != '1) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (upd && mispred && mispred_cnt_q != '1) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mispredict_q  <= 1'b0;
            actual_take_q <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q  <= mispredict_d;
            actual_take_q <= actual_take_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispredictM  = mispredict_q;
    assign actual_takeM = actual_take_q;
    assign branch_cnt   = branch_cnt_q;
    assign mispred_cnt  = mispred_cnt_q;

endmodule
